ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 152 +++++++++++++++
 tb/tb_ifetch.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch unit: word-sequential fetch into a small FIFO buffer,
// with redirect support that safely retires an in-flight bus read.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_cs,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    typedef enum logic {
        FETCH,
        DISCARD
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   pend_pc_q, pend_pc_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [31:0]   pc_q [DEPTH];
    logic [31:0]   pc_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   redir_pc;
    logic          push;
    logic          pop;
    logic          flush;

    assign redir_pc = redirect_pc & ~32'h3;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    // Bus request: suppressed during reset; in DISCARD the stalled read is kept alive
    always_comb begin
        mem_cs = 1'b0;
        if (!rst) begin
            mem_cs = (state_q == DISCARD) || (count_q < DEPTH_C);
        end
    end

    assign mem_addr    = fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = data_q[head_q];
    assign instr_pc    = pc_q[head_q];

    // Next-state: FSM, fetch/pending PCs and FIFO bookkeeping
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        data_d     = data_q;
        pc_d       = pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        push       = 1'b0;
        flush      = 1'b0;
        pop        = (count_q != '0) && instr_ready && !redirect_valid;

        case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (mem_cs && !mem_ready) begin
                        // Read cannot be cancelled: hold address until it retires
                        pend_pc_d = redir_pc;
                        state_d   = DISCARD;
                    end else begin
                        fetch_pc_d = redir_pc;
                    end
                end else if (mem_cs && mem_ready) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            DISCARD: begin
                if (redirect_valid) begin
                    pend_pc_d = redir_pc;
                end
                if (mem_ready) begin
                    fetch_pc_d = redirect_valid ? redir_pc : pend_pc_q;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                data_d[tail_q] = mem_rdata;
                pc_d[tail_q]   = fetch_pc_q;
                tail_d         = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC & ~32'h3;
            pend_pc_q  <= '0;
            data_q     <= '{default: '0};
            pc_q       <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            data_q     <= data_d;
            pc_q       <= pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch. Memory returns 0x13 + word index.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_cs;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    logic        w_mem_cs;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_rdata;
    logic        w_instr_valid;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mem_rdata   = 32'h13 + (mem_addr >> 2);
    assign w_mem_rdata = 32'h13 + (w_mem_addr >> 2);

    ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .mem_cs(mem_cs), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    ifetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst), .mem_cs(w_mem_cs), .mem_addr(w_mem_addr),
        .mem_rdata(w_mem_rdata), .mem_ready(mem_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc),
        .instr_ready(instr_ready)
    );

    // Leaves rst sampled high; the next negedge with rst=0 begins cycle 0
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        mem_ready = 1'b1; instr_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset_dut();
        @(negedge clk); #1;
        checks++; if (mem_cs !== 1'b0) begin failures++; $display("FAIL rst_cs got=%b exp=0", mem_cs); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", instr); end
        checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", instr_pc); end
        checks++; if (w_mem_cs !== 1'b0) begin failures++; $display("FAIL rst_wcs got=%b exp=0", w_mem_cs); end
    endtask

    task automatic test_stream_and_wrap();
        logic [31:0] wexp [3];
        wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
        reset_dut();
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (mem_cs !== 1'b1 || mem_addr !== 32'h0) begin failures++; $display("FAIL stream_c0 got=%b/%h exp=1/00000000", mem_cs, mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_c0_valid got=%b exp=0", instr_valid); end
        checks++; if (w_mem_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_c0_addr got=%h exp=fffffff8", w_mem_addr); end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); #1;
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'((c - 1) * 4) || instr !== 32'(32'h13 + c - 1)) begin
                failures++;
                $display("FAIL stream_c%0d got v=%b pc=%h i=%h exp v=1 pc=%h i=%h", c, instr_valid, instr_pc, instr,
                         32'((c - 1) * 4), 32'(32'h13 + c - 1));
            end
            if (c <= 3) begin
                checks++;
                if (w_instr_valid !== 1'b1 || w_instr_pc !== wexp[c-1]) begin
                    failures++;
                    $display("FAIL wrap_c%0d got v=%b pc=%h exp v=1 pc=%h", c, w_instr_valid, w_instr_pc, wexp[c-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        @(negedge clk); rst = 1'b0; instr_ready = 1'b0; #1;            // cycle 0
        checks++; if (mem_cs !== 1'b1) begin failures++; $display("FAIL bp_c0_cs got=%b exp=1", mem_cs); end
        @(negedge clk); #1;                                              // cycle 1
        checks++; if (mem_cs !== 1'b1 || mem_addr !== 32'h4) begin failures++; $display("FAIL bp_c1 got=%b/%h exp=1/00000004", mem_cs, mem_addr); end
        @(negedge clk); #1;                                              // cycle 2: full
        checks++; if (mem_cs !== 1'b0 || mem_addr !== 32'h8) begin failures++; $display("FAIL bp_full got=%b/%h exp=0/00000008", mem_cs, mem_addr); end
        @(negedge clk); #1;                                              // cycle 3: still full
        checks++; if (mem_cs !== 1'b0 || instr_pc !== 32'h0 || instr_valid !== 1'b1) begin
            failures++; $display("FAIL bp_hold got cs=%b pc=%h v=%b exp cs=0 pc=0 v=1", mem_cs, instr_pc, instr_valid); end
        instr_ready = 1'b1;
        @(negedge clk); #1;                                              // cycle 4
        checks++; if (instr_pc !== 32'h4 || instr !== 32'h14 || mem_cs !== 1'b1 || mem_addr !== 32'h8) begin
            failures++; $display("FAIL bp_pop1 got pc=%h i=%h cs=%b a=%h exp pc=4 i=14 cs=1 a=8", instr_pc, instr, mem_cs, mem_addr); end
        @(negedge clk); #1;                                              // cycle 5
        checks++; if (instr_pc !== 32'h8 || instr !== 32'h15 || instr_valid !== 1'b1) begin
            failures++; $display("FAIL bp_pop2 got pc=%h i=%h v=%b exp pc=8 i=15 v=1", instr_pc, instr, instr_valid); end
    endtask

    task automatic test_wait_states();
        reset_dut();
        @(negedge clk); rst = 1'b0;                                      // cycle 0
        @(negedge clk);                                                  // cycle 1
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk); mem_ready = 1'b0; #1;
            checks++; if (mem_cs !== 1'b1 || mem_addr !== 32'h8) begin
                failures++; $display("FAIL wait_c%0d got cs=%b a=%h exp cs=1 a=8", c, mem_cs, mem_addr); end
        end
        @(negedge clk); mem_ready = 1'b1; #1;                            // cycle 5: completes
        checks++; if (mem_addr !== 32'h8 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL wait_done got a=%h v=%b exp a=8 v=0", mem_addr, instr_valid); end
        @(negedge clk); mem_ready = 1'b0; #1;                            // cycle 6
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || instr !== 32'h15 || mem_addr !== 32'hC) begin
            failures++; $display("FAIL wait_push got v=%b pc=%h i=%h a=%h exp v=1 pc=8 i=15 a=c", instr_valid, instr_pc, instr, mem_addr); end
        @(negedge clk); #1;                                              // cycle 7
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL wait_single got v=%b exp=0", instr_valid); end
    endtask

    task automatic test_redirect_wait(input logic overwrite);
        logic [31:0] tgt;
        tgt = overwrite ? 32'h204 : 32'h100;
        reset_dut();
        @(negedge clk); rst = 1'b0;                                      // cycle 0
        @(negedge clk);                                                  // cycle 1
        @(negedge clk); mem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100; #1;  // cycle 2
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin
            failures++; $display("FAIL rdw_pre got v=%b pc=%h exp v=1 pc=4", instr_valid, instr_pc); end
        @(negedge clk); redirect_valid = overwrite; redirect_pc = 32'h205; #1;               // cycle 3
        checks++; if (mem_cs !== 1'b1 || mem_addr !== 32'h8 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL rdw_hold got cs=%b a=%h v=%b exp cs=1 a=8 v=0", mem_cs, mem_addr, instr_valid); end
        @(negedge clk); redirect_valid = 1'b0; mem_ready = 1'b1; #1;                         // cycle 4
        checks++; if (mem_cs !== 1'b1 || mem_addr !== 32'h8) begin
            failures++; $display("FAIL rdw_hold2 got cs=%b a=%h exp cs=1 a=8", mem_cs, mem_addr); end
        @(negedge clk); #1;                                                                  // cycle 5
        checks++; if (mem_addr !== tgt || instr_valid !== 1'b0) begin
            failures++; $display("FAIL rdw_next got a=%h v=%b exp a=%h v=0", mem_addr, instr_valid, tgt); end
        @(negedge clk); #1;                                                                  // cycle 6
        checks++; if (instr_valid !== 1'b1 || instr_pc !== tgt || instr !== 32'h13 + (tgt >> 2)) begin
            failures++; $display("FAIL rdw_first got v=%b pc=%h i=%h exp v=1 pc=%h i=%h", instr_valid, instr_pc, instr, tgt, 32'h13 + (tgt >> 2)); end
    endtask

    task automatic test_redirect_ready();
        reset_dut();
        @(negedge clk); rst = 1'b0;                                      // cycle 0
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h102; #1; // cycle 1
        checks++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1) begin
            failures++; $display("FAIL rdr_pre got v=%b pc=%h exp v=1 pc=0", instr_valid, instr_pc); end
        @(negedge clk); redirect_valid = 1'b0; #1;                       // cycle 2
        checks++; if (mem_addr !== 32'h100 || mem_cs !== 1'b1 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL rdr_next got a=%h cs=%b v=%b exp a=100 cs=1 v=0", mem_addr, mem_cs, instr_valid); end
        @(negedge clk); #1;                                              // cycle 3
        checks++; if (instr_pc !== 32'h100 || instr !== 32'h53 || instr_valid !== 1'b1) begin
            failures++; $display("FAIL rdr_first got v=%b pc=%h i=%h exp v=1 pc=100 i=53", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_reset_in_discard();
        reset_dut();
        @(negedge clk); rst = 1'b0; mem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300; // cycle 0
        @(negedge clk); redirect_valid = 1'b0; rst = 1'b1; #1;           // in DISCARD, reset asserted
        checks++; if (mem_cs !== 1'b0) begin failures++; $display("FAIL rstd_cs got=%b exp=0", mem_cs); end
        @(negedge clk); rst = 1'b0; mem_ready = 1'b1; #1;                // first cycle after reset
        checks++; if (mem_cs !== 1'b1 || mem_addr !== 32'h0) begin
            failures++; $display("FAIL rstd_restart got cs=%b a=%h exp cs=1 a=0", mem_cs, mem_addr); end
        @(negedge clk); #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h13) begin
            failures++; $display("FAIL rstd_first got v=%b pc=%h i=%h exp v=1 pc=0 i=13", instr_valid, instr_pc, instr); end
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        test_reset();
        test_stream_and_wrap();
        test_backpressure();
        test_wait_states();
        test_redirect_wait(1'b0);
        test_redirect_wait(1'b1);
        test_redirect_ready();
        test_reset_in_discard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
